// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  // Occupancy counts 0..2 held entries.
  localparam int unsigned OccW = 2;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [OccW-1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } pipe_state_e;

  // Number of held entries for a given state.
  function automatic logic [OccW-1:0] occ_of(pipe_state_e st);
    return OccW'(st);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage entry: control field with async reset / enable / clear,
// payload with enable only (payload keeps stale contents when dropped).
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CtrlW = 6,
  parameter int unsigned DataW = 212
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [DataW-1:0] data_i,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [DataW-1:0] data_o
);

  logic [CtrlW-1:0] ctrl_q;
  logic [DataW-1:0] data_q;

  // Control register: clear wins over load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
    end else if (clr_i) begin
      ctrl_q <= '0;
    end else if (en_i) begin
      ctrl_q <= ctrl_i;
    end
  end

  // Payload register: no reset, only loaded on enable.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. SKID=1 gives a two-entry skid buffer
// with a registered in_ready; SKID=0 gives a single register whose in_ready
// is combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DATA_W = 212,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              halt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OccW-1:0]   occupancy
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;

  logic        accept;
  logic        dequeue;

  logic              main_en, main_clr, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl;
  logic [DATA_W-1:0] main_data_d, main_data;

  logic              skid_en, skid_clr;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = (state_q != StEmpty);

  // Skid mode: in_ready comes from a flop, so out_ready never reaches it.
  if (SKID != 0) begin : g_ready_reg
    assign in_ready = in_ready_q & ~halt;
  end else begin : g_ready_comb
    assign in_ready = (~out_valid | out_ready) & ~halt;
  end

  assign accept  = in_valid & in_ready & ~flush;
  assign dequeue = out_valid & out_ready & ~halt & ~flush;

  // Next-state and entry load/clear decode; flush beats halt.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!halt) begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_en = 1'b1;
          end
        end
        StOne: begin
          if (accept && dequeue) begin
            // Main entry drains and reloads in the same cycle.
            main_en = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d = StTwo;
            skid_en = 1'b1;
          end else if (dequeue) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
          end
        end
        StTwo: begin
          if (dequeue) begin
            // Skid entry moves forward into the main slot.
            state_d        = StOne;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Room is available next cycle unless both entries will be full.
  always_comb begin
    in_ready_d = (state_d != StTwo);
  end

  // State and registered ready; ready stays low throughout reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Main entry source select: upstream beat or promoted skid entry.
  always_comb begin
    main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    main_data_d = main_from_skid ? skid_data : in_data;
  end

  pipe_entry #(
    .CtrlW (CTRL_W),
    .DataW (DATA_W)
  ) u_main (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (main_en),
    .clr_i  (main_clr),
    .ctrl_i (main_ctrl_d),
    .data_i (main_data_d),
    .ctrl_o (main_ctrl),
    .data_o (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(
      .CtrlW (CTRL_W),
      .DataW (DATA_W)
    ) u_skid (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (skid_en),
      .clr_i  (skid_clr),
      .ctrl_i (in_ctrl),
      .data_i (in_data),
      .ctrl_o (skid_ctrl),
      .data_o (skid_data)
    );
  end else begin : g_no_skid
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  // Bubbles present a zero control field.
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
  assign out_data  = main_data;
  assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (SKID=1 defaults).
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 6;
  localparam int unsigned DATA_W = 212;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              halt;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  pipe_stage_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .SKID   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .halt      (halt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  c;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ht;
    logic [1:0]  occ;  // expected occupancy just after the edge
  } vec_t;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  beat_t sb[$];
  bit    armed  = 1'b0;  // model: registered ready has seen an edge out of reset
  vec_t  vecs[$];

  function automatic logic [DATA_W-1:0] mk(input logic [31:0] d);
    logic [223:0] t;
    t = {7{d}};
    return t[DATA_W-1:0];
  endfunction

  function automatic vec_t mv(input logic v, input logic [5:0] c, input logic [31:0] d,
                              input logic ordy, input logic fl, input logic ht,
                              input logic [1:0] occ);
    vec_t t;
    t.v = v; t.c = c; t.d = d; t.ordy = ordy; t.fl = fl; t.ht = ht; t.occ = occ;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the scoreboard model for the current cycle.
  task automatic check_outputs(input logic exp_rdy);
    logic ev;
    ev = (sb.size() > 0);
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("out_valid", 256'(out_valid), 256'(ev));
    chk("occupancy", 256'(occupancy), 256'(sb.size()));
    chk("out_ctrl", 256'(out_ctrl), ev ? 256'(sb[0].c) : 256'(0));
    if (ev) chk("out_data", 256'(out_data), 256'(sb[0].d));
  endtask

  // One clock: drive at negedge, check, then advance the model at the edge.
  task automatic step(input vec_t t);
    logic  exp_rdy, acc, deq;
    beat_t b;
    @(negedge clk);
    in_valid  = t.v;
    in_ctrl   = t.c;
    in_data   = mk(t.d);
    out_ready = t.ordy;
    flush     = t.fl;
    halt      = t.ht;
    #1;
    exp_rdy = armed && (sb.size() < 2) && !t.ht;
    check_outputs(exp_rdy);
    acc = t.v && exp_rdy && !t.fl;
    deq = (sb.size() > 0) && t.ordy && !t.ht && !t.fl;
    @(posedge clk);
    #1;
    if (t.fl) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (acc) begin
        b.c = t.c;
        b.d = mk(t.d);
        sb.push_back(b);
      end
    end
    if (reset) armed = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    halt      = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state while reset is held low.
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_occupancy", 256'(occupancy), 256'(0));
    chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // First cycle after release: ready still low until an edge passes.
    step(mv(0, 0, 0, 1, 0, 0, 0));

    // Single beat, latency one cycle.
    vecs.push_back(mv(1, 6'h2A, 1, 1, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));
    // Back-to-back stream 1..8.
    for (int i = 1; i <= 8; i++) vecs.push_back(mv(1, 6'(i), 32'(i), 1, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));
    // Backpressure: 1 and 2 held, 3 refused until space frees.
    vecs.push_back(mv(1, 6'h11, 1, 0, 0, 0, 1));
    vecs.push_back(mv(1, 6'h12, 2, 0, 0, 0, 2));
    vecs.push_back(mv(1, 6'h13, 3, 0, 0, 0, 2));
    vecs.push_back(mv(1, 6'h13, 3, 1, 0, 0, 1));
    vecs.push_back(mv(1, 6'h13, 3, 1, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));
    // Flush in TWO with a concurrent beat 9.
    vecs.push_back(mv(1, 6'h14, 4, 0, 0, 0, 1));
    vecs.push_back(mv(1, 6'h15, 5, 0, 0, 0, 2));
    vecs.push_back(mv(1, 6'h19, 9, 0, 1, 0, 0));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));
    // Halt three cycles in TWO with out_ready high, then drain.
    vecs.push_back(mv(1, 6'h16, 6, 0, 0, 0, 1));
    vecs.push_back(mv(1, 6'h17, 7, 0, 0, 0, 2));
    for (int i = 0; i < 3; i++) vecs.push_back(mv(1, 6'h18, 8, 1, 0, 1, 2));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));
    // Flush wins over halt.
    vecs.push_back(mv(1, 6'h1A, 10, 0, 0, 0, 1));
    vecs.push_back(mv(1, 6'h1B, 11, 1, 1, 1, 0));
    vecs.push_back(mv(0, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      chk($sformatf("occ_after[%0d]", i), 256'(occupancy), 256'(vecs[i].occ));
    end

    // Asynchronous reset while TWO is held.
    step(mv(1, 6'h21, 12, 0, 0, 0, 1));
    step(mv(1, 6'h22, 13, 0, 0, 0, 2));
    chk("pre_reset_occ", 256'(occupancy), 256'(2));
    #2 reset = 1'b0;
    #1;
    chk("async_out_valid", 256'(out_valid), 256'(0));
    chk("async_out_ctrl", 256'(out_ctrl), 256'(0));
    chk("async_occupancy", 256'(occupancy), 256'(0));
    chk("async_in_ready", 256'(in_ready), 256'(0));
    sb.delete();
    armed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    step(mv(0, 0, 0, 1, 0, 0, 0));
    step(mv(1, 6'h23, 14, 1, 0, 0, 1));
    step(mv(0, 0, 0, 1, 0, 0, 0));
    step(mv(0, 0, 0, 1, 0, 0, 0));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step(mv(1'($urandom_range(0, 1)), 6'($urandom), $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 9) == 0), 2'd0));
    end
    // Drain whatever remains.
    for (int i = 0; i < 3; i++) step(mv(0, 0, 0, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
